// File: rtl/fft_pkg.sv
// Shared width helpers and fixed-point primitives for the radix-2 butterfly datapath.
package fft_pkg;

   // Widest supported data width: products at 2W+2 bits must fit the 64-bit helpers.
   localparam int unsigned MAX_W = 31;

   typedef struct packed {
      logic signed [63:0] val;
      logic               clip;
   } sat_t;

   function automatic int unsigned w_tw(input int unsigned w);
      return w + 1;
   endfunction

   function automatic int unsigned w_prod(input int unsigned w);
      return 2 * w + 2;
   endfunction

   function automatic int unsigned w_rnd(input int unsigned w);
      return w + 3;
   endfunction

   function automatic int unsigned w_sum(input int unsigned w);
      return w + 4;
   endfunction

   // Round-half-up arithmetic right shift; sh must be at least 1.
   function automatic logic signed [63:0] rnd_shr(input logic signed [63:0] v,
                                                  input int unsigned sh);
      logic signed [63:0] half;
      half = 64'sd1 <<< (sh - 1);
      return (v + half) >>> sh;
   endfunction

   function automatic sat_t sat(input logic signed [63:0] v, input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sat_t               r;
      hi     = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo     = -(64'sd1 <<< (w - 1));
      r.val  = v;
      r.clip = 1'b0;
      if (v > hi) begin
         r.val  = hi;
         r.clip = 1'b1;
      end else if (v < lo) begin
         r.val  = lo;
         r.clip = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bfly_r2_pipe_if.sv
// Operand/result stream between the FFT memory read ports, the butterfly and write-back.
interface bfly_r2_pipe_if #(
   parameter int unsigned W = 8
);
   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] xr0, xi0, xr1, xi1;
   logic signed [W-1:0] wr, wi;
   logic                scale;
   logic                conj_w;
   logic                out_valid;
   logic                out_ready;
   logic signed [W-1:0] yr0, yi0, yr1, yi1;
   logic                ovf;
   logic                ovf_clr;

   modport master (
      output in_valid, xr0, xi0, xr1, xi1, wr, wi, scale, conj_w, out_ready, ovf_clr,
      input  in_ready, out_valid, yr0, yi0, yr1, yi1, ovf
   );

   modport slave (
      input  in_valid, xr0, xi0, xr1, xi1, wr, wi, scale, conj_w, out_ready, ovf_clr,
      output in_ready, out_valid, yr0, yi0, yr1, yi1, ovf
   );
endinterface

// File: rtl/cmul_pipe.sv
// First butterfly stage: registered complex product x1*w, optionally with conj(w).
module cmul_pipe
   import fft_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        adv,
   input  logic                        conj_w,
   input  logic signed [W-1:0]         xr,
   input  logic signed [W-1:0]         xi,
   input  logic signed [W-1:0]         wr,
   input  logic signed [W-1:0]         wi,
   output logic signed [w_prod(W)-1:0] pr_q,
   output logic signed [w_prod(W)-1:0] pi_q
);
   localparam int unsigned WT = w_tw(W);
   localparam int unsigned WP = w_prod(W);

   logic signed [WT-1:0] wi_cj;
   logic signed [WP-1:0] pr_d;
   logic signed [WP-1:0] pi_d;

   // One extra bit keeps -(-2^(W-1)) exact when conjugating.
   always_comb begin
      wi_cj = WT'(wi);
      if (conj_w) wi_cj = -WT'(wi);
      pr_d = pr_q;
      pi_d = pi_q;
      if (adv) begin
         pr_d = WP'(xr) * WP'(wr) - WP'(xi) * WP'(wi_cj);
         pi_d = WP'(xr) * WP'(wi_cj) + WP'(xi) * WP'(wr);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pr_q <= '0;
         pi_q <= '0;
      end else begin
         pr_q <= pr_d;
         pi_q <= pi_d;
      end
   end

endmodule

// File: rtl/bfly_r2_pipe.sv
// Three-stage radix-2 DIT butterfly with valid/ready flow control, rounding,
// optional /2 scaling, output saturation and a sticky overflow flag.
module bfly_r2_pipe
   import fft_pkg::*;
#(
   parameter int unsigned W   = 8,
   parameter int unsigned LAT = 3
) (
   input logic           clk,
   input logic           rst,
   bfly_r2_pipe_if.slave bus
);
   localparam int unsigned WP = w_prod(W);
   localparam int unsigned WT = w_rnd(W);
   localparam int unsigned WS = w_sum(W);

   if (LAT != 3) begin : g_bad_lat
      $error("bfly_r2_pipe: only LAT=3 is supported");
   end
   if (W < 2 || W > MAX_W) begin : g_bad_w
      $error("bfly_r2_pipe: W out of supported range");
   end

   logic                 adv;
   logic signed [WP-1:0] pr_q, pi_q;
   logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic                 sc1_q, sc1_d, sc2_q, sc2_d;
   logic signed [W-1:0]  x0_q [2];
   logic signed [W-1:0]  x0_d [2];
   logic signed [WS-1:0] s_q  [4];
   logic signed [WS-1:0] s_d  [4];
   logic signed [W-1:0]  y_q  [4];
   logic signed [W-1:0]  y_d  [4];
   logic                 ovf_q, ovf_d;
   logic signed [WT-1:0] t    [2];
   logic signed [WS-1:0] ss   [4];
   sat_t                 sr   [4];
   logic                 clip_any;

   // Global stall: every stage moves only when the output slot can be refilled.
   assign adv          = !v3_q || bus.out_ready;
   assign bus.in_ready = adv;
   assign bus.out_valid = v3_q;
   assign bus.ovf      = ovf_q;
   assign bus.yr0      = y_q[0];
   assign bus.yi0      = y_q[1];
   assign bus.yr1      = y_q[2];
   assign bus.yi1      = y_q[3];

   cmul_pipe #(.W(W)) u_cmul (
      .clk    (clk),
      .rst    (rst),
      .adv    (adv),
      .conj_w (bus.conj_w),
      .xr     (bus.xr1),
      .xi     (bus.xi1),
      .wr     (bus.wr),
      .wi     (bus.wi),
      .pr_q   (pr_q),
      .pi_q   (pi_q)
   );

   always_comb begin
      v1_d  = v1_q;
      v2_d  = v2_q;
      v3_d  = v3_q;
      sc1_d = sc1_q;
      sc2_d = sc2_q;
      for (int k = 0; k < 2; k++) x0_d[k] = x0_q[k];
      for (int k = 0; k < 4; k++) begin
         s_d[k] = s_q[k];
         y_d[k] = y_q[k];
      end

      // Drop the Q1.(W-1) fraction of the product with round-half-up.
      t[0] = WT'(rnd_shr(64'(pr_q), W - 1));
      t[1] = WT'(rnd_shr(64'(pi_q), W - 1));

      clip_any = 1'b0;
      for (int k = 0; k < 4; k++) begin
         ss[k]    = sc2_q ? WS'(rnd_shr(64'(s_q[k]), 1)) : s_q[k];
         sr[k]    = sat(64'(ss[k]), W);
         clip_any = clip_any | sr[k].clip;
      end

      if (adv) begin
         v1_d    = bus.in_valid;
         x0_d[0] = bus.xr0;
         x0_d[1] = bus.xi0;
         sc1_d   = bus.scale;

         v2_d   = v1_q;
         sc2_d  = sc1_q;
         s_d[0] = WS'(x0_q[0]) + WS'(t[0]);
         s_d[1] = WS'(x0_q[1]) + WS'(t[1]);
         s_d[2] = WS'(x0_q[0]) - WS'(t[0]);
         s_d[3] = WS'(x0_q[1]) - WS'(t[1]);

         v3_d = v2_q;
         for (int k = 0; k < 4; k++) y_d[k] = W'(sr[k].val);
      end

      // A clip is recorded only when its result enters the output register.
      ovf_d = (ovf_q && !bus.ovf_clr) || (adv && v2_q && clip_any);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         v3_q  <= 1'b0;
         sc1_q <= 1'b0;
         sc2_q <= 1'b0;
         ovf_q <= 1'b0;
         for (int k = 0; k < 2; k++) x0_q[k] <= '0;
         for (int k = 0; k < 4; k++) begin
            s_q[k] <= '0;
            y_q[k] <= '0;
         end
      end else begin
         v1_q  <= v1_d;
         v2_q  <= v2_d;
         v3_q  <= v3_d;
         sc1_q <= sc1_d;
         sc2_q <= sc2_d;
         ovf_q <= ovf_d;
         for (int k = 0; k < 2; k++) x0_q[k] <= x0_d[k];
         for (int k = 0; k < 4; k++) begin
            s_q[k] <= s_d[k];
            y_q[k] <= y_d[k];
         end
      end
   end

endmodule
